// File: rtl/ram_io_responder.sv
// Byte-wide RAM plus a memory-mapped UART TX FIFO at 0x30000.
// Optional RAM_IO_STATUS_EN macro exposes {overflow, count} at 0x30004 with clear-on-read.
module ram_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic [31:0] addr_in,
   input  logic        rw_flag_in,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        uart_full_out,
   output logic [7:0]  tx_data_out,
   output logic        tx_valid_out,
   input  logic        tx_ready_in
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   // Valid/ready: a TX byte transfers on any rising edge where tx_valid_out and
   // tx_ready_in are both high (and rdy_in is high); tx_data_out is stable until then.

   logic [7:0]            mem_q [0:(2**ADDR_WIDTH)-1];
   logic [7:0]            fifo_mem_q [FIFO_DEPTH];

   logic [7:0]            data_out_q, data_out_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;

   logic                  io_sel;
   logic                  tx_sel;
   logic                  null_addr;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic                  ram_we;
   logic                  rd_en;
   logic                  push_req;
   logic                  push_ok;
   logic                  pop;
   logic                  fifo_full;
   logic [7:0]            io_rdata;

   assign io_sel    = (addr_in[17:16] == 2'b11);
   assign tx_sel    = (addr_in == 32'h0003_0000);
   assign null_addr = (addr_in == 32'h0000_0000);
   assign ram_idx   = addr_in[ADDR_WIDTH-1:0];

   assign ram_we    = rdy_in && rw_flag_in && !io_sel && !null_addr;
   assign rd_en     = rdy_in && !rw_flag_in;
   assign fifo_full = (count_q == CW'(FIFO_DEPTH));
   assign pop       = rdy_in && tx_valid_out && tx_ready_in;
   assign push_req  = rdy_in && rw_flag_in && tx_sel;
   // A pop in the same edge frees the head slot, so a full FIFO still accepts.
   assign push_ok   = push_req && (!fifo_full || pop);

`ifdef RAM_IO_STATUS_EN
   logic       stat_sel;
   logic [3:0] count_sat;

   assign stat_sel  = (addr_in == 32'h0003_0004);
   assign count_sat = (int'(count_q) > 15) ? 4'hF : 4'(count_q);
   assign io_rdata  = stat_sel ? {overflow_q, 3'b000, count_sat} : 8'h00;
`else
   assign io_rdata  = 8'h00;
`endif

   always_comb begin
      data_out_d = data_out_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (rd_en) begin
         data_out_d = io_sel ? io_rdata : mem_q[ram_idx];
`ifdef RAM_IO_STATUS_EN
         if (stat_sel) begin
            overflow_d = 1'b0;
         end
`endif
      end

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (push_req && !push_ok) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         data_out_q <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage arrays are deliberately not reset; RAM survives a reset.
   always_ff @(posedge clk_in) begin
      if (ram_we) begin
         mem_q[ram_idx] <= data_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         fifo_mem_q[wr_ptr_q] <= data_in;
      end
   end

   assign data_out      = data_out_q;
   assign tx_data_out   = fifo_mem_q[rd_ptr_q];
   assign tx_valid_out  = (count_q != '0);
   assign uart_full_out = (count_q >= CW'(FIFO_DEPTH - 1));

endmodule
